// File: rtl/div_result_bcd_pkg.sv
// Shared constants, FSM encoding and sizing helper for the quotient/remainder BCD converter.
package div_result_bcd_pkg;

  localparam int unsigned DIV_W       = 8;
  localparam int unsigned BCD_DIGITS  = 3;
  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Decimal digits needed to hold the largest unsigned w-bit value.
  function automatic int unsigned digits_for(int unsigned w);
    longint unsigned max_val;
    int unsigned     n;
    max_val = (64'd1 << w) - 64'd1;
    n       = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift {bcd, bin} left by one.
module bcd_dabble_step
  import div_result_bcd_pkg::*;
#(
  parameter int unsigned W      = DIV_W,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  input  logic [W-1:0]                  bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_next,
  output logic [W-1:0]                  bin_next
);

  localparam int unsigned BW = BCD_DIGIT_W * DIGITS;

  logic [BW-1:0] adj;

  // Digits are adjusted independently; no carry crosses a digit boundary.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
        adj[d*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
    end
  end

  assign {bcd_next, bin_next} = {adj[BW-2:0], bin, 1'b0};

endmodule

// File: rtl/div_result_bcd.sv
// Converts the divider's quotient and remainder to packed BCD in parallel, one bit per clock.
module div_result_bcd
  import div_result_bcd_pkg::*;
#(
  parameter int unsigned W      = DIV_W,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  Q,
  input  logic [W-1:0]                  R,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] q_bcd,
  output logic [BCD_DIGIT_W*DIGITS-1:0] r_bcd,
  output logic                          busy
);

  localparam int unsigned BW        = BCD_DIGIT_W * DIGITS;
  localparam int unsigned STEP_W    = $clog2(W) + 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(W - 1);

  generate
    if (digits_for(W) > DIGITS) begin : g_digits_chk
      $error("div_result_bcd: DIGITS too small for W-bit operands");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [W-1:0]      q_bin_q, q_bin_d, r_bin_q, r_bin_d;
  logic [BW-1:0]     q_acc_q, q_acc_d, r_acc_q, r_acc_d;
  logic [BW-1:0]     q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;

  logic [W-1:0]      q_bin_nxt, r_bin_nxt;
  logic [BW-1:0]     q_acc_nxt, r_acc_nxt;

  bcd_dabble_step #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_step_q (
    .bcd      (q_acc_q),
    .bin      (q_bin_q),
    .bcd_next (q_acc_nxt),
    .bin_next (q_bin_nxt)
  );

  bcd_dabble_step #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_step_r (
    .bcd      (r_acc_q),
    .bin      (r_bin_q),
    .bcd_next (r_acc_nxt),
    .bin_next (r_bin_nxt)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    q_bin_d = q_bin_q;
    r_bin_d = r_bin_q;
    q_acc_d = q_acc_q;
    r_acc_d = r_acc_q;
    q_bcd_d = q_bcd_q;
    r_bcd_d = r_bcd_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StShift;
          step_d  = '0;
          q_bin_d = Q;
          r_bin_d = R;
          q_acc_d = '0;
          r_acc_d = '0;
        end
      end
      StShift: begin
        step_d  = step_q + STEP_W'(1);
        q_bin_d = q_bin_nxt;
        r_bin_d = r_bin_nxt;
        q_acc_d = q_acc_nxt;
        r_acc_d = r_acc_nxt;
        // Outputs are published straight from the final step so they appear with out_valid.
        if (step_q == LAST_STEP) begin
          state_d = StDone;
          q_bcd_d = q_acc_nxt;
          r_bcd_d = r_acc_nxt;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      q_bin_q <= '0;
      r_bin_q <= '0;
      q_acc_q <= '0;
      r_acc_q <= '0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      q_bin_q <= q_bin_d;
      r_bin_q <= r_bin_d;
      q_acc_q <= q_acc_d;
      r_acc_q <= r_acc_d;
      q_bcd_q <= q_bcd_d;
      r_bcd_q <= r_bcd_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StShift);
  assign out_valid = (state_q == StDone);
  assign q_bcd     = q_bcd_q;
  assign r_bcd     = r_bcd_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd with a cycle-level decimal reference model.
module tb_div_result_bcd;

  localparam int unsigned W      = 8;
  localparam int unsigned DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Q;
  logic [7:0]  R;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] q_bcd;
  logic [11:0] r_bcd;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_result_bcd #(
    .W      (W),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q         (Q),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd),
    .busy      (busy)
  );

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] res;
    int          x;
    x   = v;
    res = '0;
    for (int d = 0; d < 3; d++) begin
      res[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 converting (m_left edges to go), 2 done.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [7:0]  cap_q, cap_r;
  logic [11:0] m_q, m_r;
  bit          live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_q     = '0;
      m_r     = '0;
      live    = 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          cap_q   = Q;
          cap_r   = R;
          m_left  = W;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            m_q     = to_bcd(int'(cap_q));
            m_r     = to_bcd(int'(cap_r));
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      check("busy", {31'd0, busy}, {31'd0, m_phase == 1});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
      check("q_bcd", {20'd0, q_bcd}, {20'd0, m_q});
      check("r_bcd", {20'd0, r_bcd}, {20'd0, m_r});
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Accept one pair; returns once out_valid is seen, with lat = edges after the accept edge.
  task automatic convert(input logic [7:0] q, input logic [7:0] r, output int lat);
    wait_ready();
    Q        = q;
    R        = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 32'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Q         = '0;
    R         = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_q_bcd", {20'd0, q_bcd}, 32'h000);
    check("rst_r_bcd", {20'd0, r_bcd}, 32'h000);

    // 32 / 3
    convert(8'd10, 8'd2, lat);
    check("div32_3_q", {20'd0, q_bcd}, 32'h010);
    check("div32_3_r", {20'd0, r_bcd}, 32'h002);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("div32_3_idle", {31'd0, in_ready}, 32'd1);

    convert(8'd255, 8'd0, lat);
    check("ext1_q", {20'd0, q_bcd}, 32'h255);
    check("ext1_r", {20'd0, r_bcd}, 32'h000);
    convert(8'd0, 8'd255, lat);
    check("ext2_q", {20'd0, q_bcd}, 32'h000);
    check("ext2_r", {20'd0, r_bcd}, 32'h255);

    for (int i = 0; i < 256; i++) begin
      convert(8'(i), 8'(i) ^ 8'hFF, lat);
      check("sweep_q", {20'd0, q_bcd}, {20'd0, to_bcd(i)});
      check("sweep_r", {20'd0, r_bcd}, {20'd0, to_bcd(255 - i)});
      @(posedge clk); #1;
      check("sweep_ready", {31'd0, in_ready}, 32'd1);
    end

    // Back-pressure with an ignored operand in DONE.
    out_ready = 1'b0;
    convert(8'd123, 8'd45, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        Q        = 8'd99;
        R        = 8'd99;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_q", {20'd0, q_bcd}, 32'h123);
      check("bp_r", {20'd0, r_bcd}, 32'h045);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    Q         = 8'd99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_idle", {31'd0, in_ready}, 32'd1);
    check("release_busy", {31'd0, busy}, 32'd0);
    check("release_q", {20'd0, q_bcd}, 32'h123);
    @(posedge clk); #1;
    check("no_accept", {31'd0, busy}, 32'd0);

    // Reset mid-conversion.
    wait_ready();
    Q        = 8'd200;
    R        = 8'd55;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr_in_ready", {31'd0, in_ready}, 32'd1);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_q", {20'd0, q_bcd}, 32'h000);
    check("mr_r", {20'd0, r_bcd}, 32'h000);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("mr_no_valid", {31'd0, seen}, 32'd0);

    convert(8'd7, 8'd1, lat);
    check("fresh_q", {20'd0, q_bcd}, 32'h007);
    check("fresh_r", {20'd0, r_bcd}, 32'h001);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
